// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the router output synchroniser.
//   NUM_PORTS_DEF / TIMEOUT_DEF / CNT_W_DEF : default parameter values
//   STAT_W                                  : width of per-port timeout status counters
//   port_idx_t                              : port index type (covers up to 16 ports)
package router_pkg;

  localparam int NUM_PORTS_DEF = 3;
  localparam int TIMEOUT_DEF   = 30;
  localparam int CNT_W_DEF     = 5;
  localparam int STAT_W        = 8;

  typedef logic [3:0] port_idx_t;

endpackage

// File: rtl/router_sync_wdog.sv
// router_sync_wdog: single-port FIFO watchdog.
// Counts consecutive cycles where the port holds valid data that nobody reads;
// after TIMEOUT+1 such cycles it emits a one-cycle soft_reset pulse and starts over.
// Optional macro ROUTER_SYNC_TO_STATUS_EN adds an 8-bit saturating pulse counter.
// Ports:
//   clock      in   rising-edge clock
//   resetn     in   asynchronous reset, active HIGH
//   vld        in   port holds unread data (FIFO not empty)
//   rd         in   reader strobe for this port
//   soft_reset out  one-cycle FIFO flush pulse
//   to_cnt     out  saturating soft_reset pulse count (only with ROUTER_SYNC_TO_STATUS_EN)
module router_sync_wdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              vld,
  input  logic              rd,
  output logic              soft_reset
`ifdef ROUTER_SYNC_TO_STATUS_EN
  ,
  output logic [STAT_W-1:0] to_cnt
`endif
);

  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(0);

  logic [CNT_W-1:0] cnt;

  // Unattended-valid counter and flush pulse generation.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      cnt        <= ZERO;
      soft_reset <= 1'b0;
    end else if (!vld || rd) begin
      // Any empty or read cycle means the data is being attended to.
      cnt        <= ZERO;
      soft_reset <= 1'b0;
    end else if (cnt == TMO) begin
      // TIMEOUT+1-th consecutive unattended edge: flush and restart counting.
      cnt        <= ZERO;
      soft_reset <= 1'b1;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      soft_reset <= 1'b0;
    end
  end

`ifdef ROUTER_SYNC_TO_STATUS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Saturating count of flush pulses; only a reset clears it.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      to_cnt <= STAT_W'(0);
    end else if (soft_reset && (to_cnt != STAT_MAX)) begin
      to_cnt <= to_cnt + STAT_W'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end
`endif

endmodule

// File: rtl/router_sync_n.sv
// router_sync_n: synchroniser between the router packet-control FSM and its
// NUM_PORTS output FIFOs. Latches the destination address on header detect,
// steers a one-hot write enable, selects the addressed FIFO's full flag,
// derives valid-out from the FIFO empties and runs a per-port watchdog.
// Optional macro ROUTER_SYNC_TO_STATUS_EN adds the to_cnt status output.
// Ports:
//   clock          in   rising-edge clock
//   resetn         in   asynchronous reset, active HIGH (1 = reset)
//   detect_add     in   header byte present on data_in
//   data_in        in   destination address field
//   write_enb_reg  in   FSM requests a FIFO write
//   full           in   per-FIFO full flags
//   empty          in   per-FIFO empty flags
//   read_enb       in   per-port reader strobes
//   write_enb      out  one-hot FIFO write enable
//   fifo_full      out  full flag of the addressed FIFO
//   addr_err       out  latched address is out of range
//   vld_out        out  per-port valid (~empty)
//   soft_reset     out  per-port one-cycle FIFO flush pulse
//   to_cnt         out  per-port 8-bit timeout counts (only with ROUTER_SYNC_TO_STATUS_EN)
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = $clog2(NUM_PORTS),
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        detect_add,
  input  logic [ADDR_W-1:0]           data_in,
  input  logic                        write_enb_reg,
  input  logic [NUM_PORTS-1:0]        full,
  input  logic [NUM_PORTS-1:0]        empty,
  input  logic [NUM_PORTS-1:0]        read_enb,
  output logic [NUM_PORTS-1:0]        write_enb,
  output logic                        fifo_full,
  output logic                        addr_err,
  output logic [NUM_PORTS-1:0]        vld_out,
  output logic [NUM_PORTS-1:0]        soft_reset
`ifdef ROUTER_SYNC_TO_STATUS_EN
  ,
  output logic [NUM_PORTS*STAT_W-1:0] to_cnt
`endif
);

  // Port count at one bit wider than the address so 2^ADDR_W ports compare correctly.
  localparam logic [ADDR_W:0] NP = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0]    addr_q;
  logic                 addr_vld;
  logic                 addr_ok;
  logic [NUM_PORTS-1:0] sel;

  // Destination address latch, loaded on header detect.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      addr_q   <= ADDR_W'(0);
      addr_vld <= 1'b0;
    end else if (detect_add) begin
      addr_q   <= data_in;
      addr_vld <= 1'b1;
    end else begin
      addr_q   <= addr_q;
      addr_vld <= addr_vld;
    end
  end

  // Address range check and one-hot port select from the latched address.
  always_comb begin
    addr_err = 1'b0;
    addr_ok  = 1'b0;
    sel      = {NUM_PORTS{1'b0}};
    if (addr_vld) begin
      addr_err = ({1'b0, addr_q} >= NP);
    end else begin
      addr_err = 1'b0;
    end
    addr_ok = addr_vld && !addr_err;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_ok && (port_idx_t'(addr_q) == port_idx_t'(i))) begin
        sel[i] = 1'b1;
      end else begin
        sel[i] = 1'b0;
      end
    end
  end

  // Write steering and full-flag selection; a port being flushed never gets a write.
  always_comb begin
    write_enb = {NUM_PORTS{1'b0}};
    fifo_full = 1'b0;
    if (write_enb_reg) begin
      write_enb = sel & ~soft_reset;
    end else begin
      write_enb = {NUM_PORTS{1'b0}};
    end
    fifo_full = |(full & sel);
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wdog
    router_sync_wdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_wdog (
      .clock      (clock),
      .resetn     (resetn),
      .vld        (vld_out[g]),
      .rd         (read_enb[g]),
      .soft_reset (soft_reset[g])
`ifdef ROUTER_SYNC_TO_STATUS_EN
      ,
      .to_cnt     (to_cnt[g*STAT_W +: STAT_W])
`endif
    );
  end

endmodule
